instr_blit_ctrl: RTL and testbench
==================================

// Module: instr_blit_ctrl
// PURPOSE
//  Sequencer that copies one instruction page (IMG_W x IMG_H, 8-bit pixels) from instr_mem into the frame buffer.
//  Sits between the game FSM (start/done) and the shared frame-buffer write port.
//  Walks pixels row-major, absorbs ROM read latency, clips to the screen and stalls on write backpressure.
// PARAMETERS
//  IMG_W        237    page width in pixels
//  IMG_H        21     page height in rows
//  PAGE_OFFSET  4977   ROM word offset of page 1 (page 0 starts at 0)
//  FB_W         320    frame-buffer width
//  FB_H         240    frame-buffer height
//  ROM_LAT      1      instr_mem cycles from address to q (>=1)
//  TRANSP_KEY   8'hE3  colour skipped when transparency is compiled in
// PORTS
//  vga_clk      in   1   sole clock
//  reset        in   1   synchronous, active-high
//  start        in   1   1-cycle request; sampled only in IDLE
//  instr_type   in   1   page select (0/1); latched on accepted start
//  org_x        in   9   screen x of page top-left; latched on start
//  org_y        in   8   screen y of page top-left; latched on start
//  busy         out  1   high from cycle after accepted start until done
//  done         out  1   1-cycle pulse: page finished
//  rom_addr     out  14  instr_mem address = instr_type*PAGE_OFFSET + y*IMG_W + x
//  rom_q        in   8   instr_mem data, valid ROM_LAT cycles after rom_addr
//  fb_wr_valid  out  1   write request; held until accepted
//  fb_wr_ready  in   1   frame-buffer accepts when valid&&ready at clock edge
//  fb_wr_addr   out  17  (org_y+y)*FB_W + (org_x+x)
//  fb_wr_data   out  8   pixel; stable while valid
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, fb_wr_valid=0, rom_addr=0, fb_wr_addr=0, fb_wr_data=0, x=y=0.
//  FSM IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | DONE) -> IDLE.
//  IDLE: start=1 latches instr_type/org_x/org_y, clears x,y -> ISSUE. start in any other state ignored.
//  ISSUE: drive rom_addr for (x,y). If screen pixel clipped (org_x+x>=FB_W or org_y+y>=FB_H, 10-bit
//   compare, no wrap) -> skip: advance, no ROM wait (1 cycle/pixel). Else -> WAIT.
//  WAIT: ROM_LAT cycles; last cycle registers rom_q into fb_wr_data, loads fb_wr_addr -> WRITE.
//  WRITE: fb_wr_valid=1; stay while fb_wr_ready=0 (addr/data frozen); on handshake advance.
//  Advance: x+1; at x==IMG_W-1 wrap x=0, y+1; after (IMG_W-1, IMG_H-1) -> DONE.
//  Unclipped pixel with ready=1 costs 2+ROM_LAT cycles (3 at default).
//  DONE: done=1 for one cycle, busy=0 in same cycle -> IDLE. A start in DONE is ignored.
//  fb_wr_valid never asserted outside WRITE; at most one write per pixel; order strictly row-major.
//  Address math unsigned, widths extended before multiply; max rom_addr 2*4977-1 fits 14 bits.
//  reset mid-operation: next edge forces IDLE, valid drops, no done pulse; partial page left as-is.
// CONFIGURATION
//  INSTR_BLIT_TRANSPARENT_EN defined: in last WAIT cycle, rom_q==TRANSP_KEY -> skip WRITE, advance directly
//   (pixel costs 1+ROM_LAT cycles, frame buffer untouched).
//  Undefined: every unclipped pixel written, including TRANSP_KEY values.
// STRUCTURE
//  Package instr_blit_pkg: state enum (IDLE/ISSUE/WAIT/WRITE/DONE), IMG_W/IMG_H/PAGE_OFFSET defaults,
//   address width constants.
//  Sub-module instr_blit_addr: combinational rom/fb address + clip flag from (x,y,org,page).
// TESTING
//  1 page0, org(0,0), ready=1: 4977 writes, first addr0 data=ROM[0], last fb 20*320+236; done at 14931 cycles.
//  2 page1, org(10,5): first rom_addr=4977, first fb_wr_addr=5*320+10=1610; row wrap x 236->0 correct.
//  3 org(200,230): only x<120, y<10 written (1200 writes); clipped pixels 1 cycle, no ROM wait.
//  4 random fb_wr_ready (50%): addr/data stable while stalled, no lost/duplicated writes, order kept.
//  5 start while busy and in DONE ignored; reset at pixel 1000 -> valid low next cycle, no done, restart clean.
//  6 TRANSPARENT_EN, ROM with TRANSP_KEY at 100 pixels: 4877 writes; without macro: 4977.

Source files
------------

// File: rtl/instr_blit_pkg.sv
// Shared geometry, address widths and sequencer state encoding for instr_blit_ctrl.
// INSTR_BLIT_TRANSPARENT_EN (see instr_blit_ctrl) makes TRANSP_KEY pixels skip the frame-buffer write.
package instr_blit_pkg;
   localparam int IMG_W       = 237;
   localparam int IMG_H       = 21;
   localparam int PAGE_OFFSET = 4977;
   localparam int FB_W        = 320;
   localparam int FB_H        = 240;
   localparam int ROM_LAT     = 1;
   localparam logic [7:0] TRANSP_KEY = 8'hE3;

   localparam int X_W    = 8;
   localparam int Y_W    = 5;
   localparam int ROM_AW = 14;
   localparam int FB_AW  = 17;
   localparam int SCR_W  = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } blit_state_e;
endpackage

// File: rtl/instr_blit_addr.sv
// Combinational address unit: ROM word address, frame-buffer address and clip flag
// for page pixel (x,y) placed at screen origin (org_x,org_y).
module instr_blit_addr
   import instr_blit_pkg::*;
(
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   input  logic              page,
   input  logic [8:0]        org_x,
   input  logic [7:0]        org_y,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [FB_AW-1:0]  fb_addr,
   output logic              clip
);
   logic [SCR_W-1:0]  scr_x_s;
   logic [SCR_W-1:0]  scr_y_s;
   logic [ROM_AW-1:0] page_base_s;

   // screen position is widened to 10 bits so an off-screen origin never wraps back on screen
   always_comb begin
      scr_x_s = SCR_W'(org_x) + SCR_W'(x);
      scr_y_s = SCR_W'(org_y) + SCR_W'(y);
      if (page) begin
         page_base_s = ROM_AW'(PAGE_OFFSET);
      end else begin
         page_base_s = {ROM_AW{1'b0}};
      end
      clip     = (scr_x_s >= SCR_W'(FB_W)) || (scr_y_s >= SCR_W'(FB_H));
      rom_addr = page_base_s + ROM_AW'(y) * ROM_AW'(IMG_W) + ROM_AW'(x);
      fb_addr  = FB_AW'(scr_y_s) * FB_AW'(FB_W) + FB_AW'(scr_x_s);
   end
endmodule

// File: rtl/instr_blit_ctrl.sv
// Instruction-page blitter: walks an IMG_W x IMG_H page row-major from instr_mem into the frame buffer.
// Define INSTR_BLIT_TRANSPARENT_EN to drop TRANSP_KEY pixels instead of writing them.
module instr_blit_ctrl
   import instr_blit_pkg::*;
(
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              start,
   input  logic              instr_type,
   input  logic [8:0]        org_x,
   input  logic [7:0]        org_y,
   output logic              busy,
   output logic              done,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_q,
   output logic              fb_wr_valid,
   input  logic              fb_wr_ready,
   output logic [FB_AW-1:0]  fb_wr_addr,
   output logic [7:0]        fb_wr_data
);
   localparam int WC_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   blit_state_e       state_r, state_nxt_s;
   logic [X_W-1:0]    x_r, x_nxt_s;
   logic [Y_W-1:0]    y_r, y_nxt_s;
   logic              page_r, page_nxt_s;
   logic [8:0]        org_x_r, org_x_nxt_s;
   logic [7:0]        org_y_r, org_y_nxt_s;
   logic [WC_W-1:0]   wait_cnt_r;
   logic              busy_r, done_r, valid_r, clip_r;
   logic [ROM_AW-1:0] rom_addr_r;
   logic [FB_AW-1:0]  fb_addr_r, fb_calc_r;
   logic [7:0]        fb_data_r;
   logic [ROM_AW-1:0] rom_calc_s;
   logic [FB_AW-1:0]  fb_calc_s;
   logic              clip_s, accept_s, advance_s, last_px_s, wait_last_s, key_hit_s;

   assign last_px_s   = (x_r == X_W'(IMG_W - 1)) && (y_r == Y_W'(IMG_H - 1));
   assign wait_last_s = (wait_cnt_r == WC_W'(ROM_LAT - 1));
`ifdef INSTR_BLIT_TRANSPARENT_EN
   assign key_hit_s   = (rom_q == TRANSP_KEY);
`else
   assign key_hit_s   = 1'b0;
`endif

   // next-state decode; advance_s marks the cycle a pixel is retired
   always_comb begin
      state_nxt_s = state_r;
      advance_s   = 1'b0;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s    = 1'b1;
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (clip_r) begin
               advance_s   = 1'b1;
               state_nxt_s = last_px_s ? DONE : ISSUE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         WAIT: begin
            if (!wait_last_s) begin
               state_nxt_s = WAIT;
            end else if (key_hit_s) begin
               advance_s   = 1'b1;
               state_nxt_s = last_px_s ? DONE : ISSUE;
            end else begin
               state_nxt_s = WRITE;
            end
         end
         WRITE: begin
            if (fb_wr_ready) begin
               advance_s   = 1'b1;
               state_nxt_s = last_px_s ? DONE : ISSUE;
            end else begin
               state_nxt_s = WRITE;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // next coordinates/job parameters; the address unit runs on these so its results can be registered
   always_comb begin
      x_nxt_s     = x_r;
      y_nxt_s     = y_r;
      page_nxt_s  = page_r;
      org_x_nxt_s = org_x_r;
      org_y_nxt_s = org_y_r;
      if (accept_s) begin
         x_nxt_s     = {X_W{1'b0}};
         y_nxt_s     = {Y_W{1'b0}};
         page_nxt_s  = instr_type;
         org_x_nxt_s = org_x;
         org_y_nxt_s = org_y;
      end else if (advance_s) begin
         if (x_r == X_W'(IMG_W - 1)) begin
            x_nxt_s = {X_W{1'b0}};
            if (last_px_s) begin
               y_nxt_s = {Y_W{1'b0}};
            end else begin
               y_nxt_s = y_r + Y_W'(1);
            end
         end else begin
            x_nxt_s = x_r + X_W'(1);
         end
      end else begin
         x_nxt_s = x_r;
         y_nxt_s = y_r;
      end
   end

   instr_blit_addr u_addr (
      .x        (x_nxt_s),
      .y        (y_nxt_s),
      .page     (page_nxt_s),
      .org_x    (org_x_nxt_s),
      .org_y    (org_y_nxt_s),
      .rom_addr (rom_calc_s),
      .fb_addr  (fb_calc_s),
      .clip     (clip_s)
   );

   // FSM state register with status outputs decoded from the next state
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ISSUE) || (state_nxt_s == WAIT) || (state_nxt_s == WRITE);
         done_r  <= (state_nxt_s == DONE);
         valid_r <= (state_nxt_s == WRITE);
      end
   end

   // coordinate, address and write-data registers; data/addr only change on the last WAIT cycle
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         x_r        <= {X_W{1'b0}};
         y_r        <= {Y_W{1'b0}};
         page_r     <= 1'b0;
         org_x_r    <= 9'd0;
         org_y_r    <= 8'd0;
         rom_addr_r <= {ROM_AW{1'b0}};
         fb_calc_r  <= {FB_AW{1'b0}};
         clip_r     <= 1'b0;
         fb_addr_r  <= {FB_AW{1'b0}};
         fb_data_r  <= 8'd0;
         wait_cnt_r <= {WC_W{1'b0}};
      end else begin
         x_r        <= x_nxt_s;
         y_r        <= y_nxt_s;
         page_r     <= page_nxt_s;
         org_x_r    <= org_x_nxt_s;
         org_y_r    <= org_y_nxt_s;
         rom_addr_r <= rom_calc_s;
         fb_calc_r  <= fb_calc_s;
         clip_r     <= clip_s;
         if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
            if (wait_last_s) begin
               fb_data_r <= rom_q;
               fb_addr_r <= fb_calc_r;
            end else begin
               fb_data_r <= fb_data_r;
               fb_addr_r <= fb_addr_r;
            end
         end else begin
            wait_cnt_r <= {WC_W{1'b0}};
         end
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign rom_addr    = rom_addr_r;
   assign fb_wr_valid = valid_r;
   assign fb_wr_addr  = fb_addr_r;
   assign fb_wr_data  = fb_data_r;
endmodule

// File: tb/tb_instr_blit_ctrl.sv
// Self-checking bench for instr_blit_ctrl: table of page jobs, random jobs/backpressure
// against a pixel-list reference model, plus reset and ignored-start sequences.
module tb_instr_blit_ctrl;
   localparam int IMG_W    = 237;
   localparam int IMG_H    = 21;
   localparam int PAGE_OFF = 4977;
   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int LIMIT    = 40000;
   localparam logic [7:0] KEY = 8'hE3;
`ifdef INSTR_BLIT_TRANSPARENT_EN
   localparam int KEY_WR = 4877;
   localparam int KEY_CYC = 14831;
`else
   localparam int KEY_WR = 4977;
   localparam int KEY_CYC = 14931;
`endif

   logic        vga_clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        instr_type = 1'b0;
   logic [8:0]  org_x = 9'd0;
   logic [7:0]  org_y = 8'd0;
   logic        busy, done, fb_wr_valid;
   logic        fb_wr_ready = 1'b0;
   logic [13:0] rom_addr;
   logic [7:0]  rom_q = 8'd0;
   logic [16:0] fb_wr_addr;
   logic [7:0]  fb_wr_data;

   instr_blit_ctrl dut (
      .vga_clk(vga_clk), .reset(reset), .start(start), .instr_type(instr_type),
      .org_x(org_x), .org_y(org_y), .busy(busy), .done(done), .rom_addr(rom_addr),
      .rom_q(rom_q), .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
      .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data)
   );

   always #5 vga_clk = ~vga_clk;

   logic [7:0] rom [0:2*PAGE_OFF-1];
   always @(posedge vga_clk) rom_q <= rom[rom_addr];

   typedef struct { int addr; int data; } wr_t;
   typedef struct { int page; int ox; int oy; int pct; bit keys; int exp_wr; int exp_cyc; } vec_t;

   wr_t exp_q[$];
   int  n_chk = 0, n_fail = 0, n_wr = 0, ready_pct = 100;
   bit  mon_en = 1'b0, prev_stall = 1'b0;
   int  prev_addr = 0, prev_data = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: every page pixel in row-major order, kept if on screen (and not a key when transparent)
   task automatic model(input int page, input int ox, input int oy, output int cyc);
      wr_t w;
      cyc = 0;
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            int d;
            if (ox + x >= FB_W || oy + y >= FB_H) begin
               cyc += 1;
            end else begin
               d = int'(rom[page*PAGE_OFF + y*IMG_W + x]);
`ifdef INSTR_BLIT_TRANSPARENT_EN
               if (d == int'(KEY)) begin
                  cyc += 2;
                  continue;
               end
`endif
               cyc += 3;
               w.addr = (oy + y)*FB_W + ox + x;
               w.data = d;
               exp_q.push_back(w);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge vga_clk);
      #1;
      fb_wr_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < ready_pct);
   end

   initial forever begin
      wr_t e;
      @(negedge vga_clk);
      if (mon_en && fb_wr_valid) begin
         if (prev_stall) begin
            chk("stall_addr", int'(fb_wr_addr), prev_addr);
            chk("stall_data", int'(fb_wr_data), prev_data);
         end
         if (fb_wr_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL extra_write: got addr %0d expected no write", fb_wr_addr);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", int'(fb_wr_addr), e.addr);
               chk("wr_data", int'(fb_wr_data), e.data);
            end
            n_wr++;
         end
         prev_stall = !fb_wr_ready;
         prev_addr  = int'(fb_wr_addr);
         prev_data  = int'(fb_wr_data);
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic run_job(input int page, input int ox, input int oy, input bit poke,
                          input string tag, output int cyc, output int writes);
      int mcyc, mcnt;
      exp_q.delete();
      model(page, ox, oy, mcyc);
      mcnt = exp_q.size();
      n_wr = 0;
      @(posedge vga_clk); #1;
      instr_type = page[0];
      org_x = ox[8:0];
      org_y = oy[7:0];
      start = 1'b1;
      @(posedge vga_clk); #1;
      start = 1'b0;
      chk($sformatf("%s_busy", tag), int'(busy), 1);
      chk($sformatf("%s_rom_addr0", tag), int'(rom_addr), page*PAGE_OFF);
      cyc = 0;
      while (!done && cyc < LIMIT) begin
         @(posedge vga_clk); #1;
         cyc++;
         if (poke && cyc == 20) begin
            start = 1'b1;
            org_x = 9'd7;
            org_y = 8'd9;
            instr_type = ~instr_type;
         end else begin
            start = 1'b0;
         end
      end
      chk($sformatf("%s_done", tag), int'(done), 1);
      chk($sformatf("%s_busy_at_done", tag), int'(busy), 0);
      if (poke) start = 1'b1;
      @(posedge vga_clk); #1;
      start = 1'b0;
      chk($sformatf("%s_done_one_cycle", tag), int'(done), 0);
      @(posedge vga_clk); #1;
      chk($sformatf("%s_idle_after", tag), int'(busy), 0);
      if (ready_pct >= 100) chk($sformatf("%s_cycles_model", tag), cyc, mcyc);
      chk($sformatf("%s_writes_model", tag), n_wr, mcnt);
      chk($sformatf("%s_queue_empty", tag), exp_q.size(), 0);
      writes = n_wr;
   endtask

   initial begin : main
      vec_t tbl [7];
      int   cyc, wr, k, dones;
      logic [7:0] b;

      for (int i = 0; i < 2*PAGE_OFF; i++) begin
         b = 8'($urandom_range(255, 0));
         rom[i] = (b == KEY) ? 8'h1C : b;
      end
      tbl[0] = '{0,   0,   0, 100, 1'b0, 4977, 14931};
      tbl[1] = '{1,  10,   5, 100, 1'b0, 4977, 14931};
      tbl[2] = '{0, 200, 230, 100, 1'b0, 1200,  7377};
      tbl[3] = '{1, 280, 100,  50, 1'b0,  840,    -1};
      tbl[4] = '{0, 319, 239, 100, 1'b0,    1,  4979};
      tbl[5] = '{1,  83, 219, 100, 1'b0, 4977, 14931};
      tbl[6] = '{0,   0,   0, 100, 1'b1, KEY_WR, KEY_CYC};

      repeat (3) @(posedge vga_clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(fb_wr_valid), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_fb_addr", int'(fb_wr_addr), 0);
      chk("rst_fb_data", int'(fb_wr_data), 0);
      reset = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].keys) begin
            for (int j = 0; j < 100; j++) rom[7 + 49*j] = KEY;
         end
         ready_pct = tbl[i].pct;
         run_job(tbl[i].page, tbl[i].ox, tbl[i].oy, 1'b0, $sformatf("row%0d", i), cyc, wr);
         chk($sformatf("row%0d_writes", i), wr, tbl[i].exp_wr);
         if (tbl[i].exp_cyc >= 0) chk($sformatf("row%0d_cycles", i), cyc, tbl[i].exp_cyc);
      end

      ready_pct = 70;
      run_job(int'($urandom_range(1, 0)), int'($urandom_range(330, 220)),
              int'($urandom_range(245, 200)), 1'b0, "rand", cyc, wr);

      // reset part-way through a page, then a clean restart with ignored start pulses
      ready_pct = 100;
      exp_q.delete();
      model(1, 0, 0, cyc);
      n_wr = 0;
      @(posedge vga_clk); #1;
      instr_type = 1'b1;
      org_x = 9'd0;
      org_y = 8'd0;
      start = 1'b1;
      @(posedge vga_clk); #1;
      start = 1'b0;
      k = 0;
      while (n_wr < 1000 && k < LIMIT) begin
         @(posedge vga_clk); #1;
         k++;
      end
      chk("rst_mid_progress", int'(n_wr >= 1000), 1);
      reset = 1'b1;
      mon_en = 1'b0;
      @(posedge vga_clk); #1;
      chk("rst_mid_valid", int'(fb_wr_valid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      dones = int'(done);
      repeat (2) begin
         @(posedge vga_clk); #1;
         dones += int'(done);
      end
      reset = 1'b0;
      repeat (3) begin
         @(posedge vga_clk); #1;
         dones += int'(done) + int'(busy);
      end
      chk("rst_mid_no_done", dones, 0);
      mon_en = 1'b1;
      run_job(0, 300, 220, 1'b1, "restart", cyc, wr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
